// File: rtl/cross_product_seq_if.sv
// Operand/result handshake bundle for cross_product_seq.
// Latency: none (wiring only).
// Backpressure: valid/ready on both sides; master = producer/consumer, slave = the unit.
//
// Signals: in_valid/in_ready/in_a/in_b carry one operand pair, packed {x,y,z};
//          out_valid/out_ready/out_c carry the result, packed {x,y,z}.
interface cross_product_seq_if #(
  parameter int WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [3*WIDTH-1:0] in_a;
  logic [3*WIDTH-1:0] in_b;
  logic               out_valid;
  logic               out_ready;
  logic [3*WIDTH-1:0] out_c;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_c
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_c
  );
endinterface

// File: rtl/cross_product_seq.sv
// Fixed-point cross product c = a x b using one shared pipelined multiplier.
// Latency: out_valid rises 6+MUL_LAT cycles after the accepting edge; no overlap of operations.
// Backpressure: in_ready only in IDLE; result held in DONE for as long as out_ready stays low.
//
// Ports: clk, rst_n (synchronous, active-low); io (slave modport): in_valid/in_ready/in_a/in_b,
//        out_valid/out_ready/out_c, all vectors packed {x,y,z}; busy = not IDLE.
// Format is signed Q(WIDTH-FRAC).FRAC; MUL_LAT must be 1..4, FRAC must be 1..WIDTH.
module cross_product_seq #(
  parameter int WIDTH   = 32,
  parameter int FRAC    = 16,
  parameter int MUL_LAT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  cross_product_seq_if.slave  io,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [3*WIDTH-1:0] a_q, a_d;
  logic [3*WIDTH-1:0] b_q, b_d;
  logic [3*WIDTH-1:0] c_q, c_d;
  logic [2:0]         k_q, k_d;
  logic [WIDTH-1:0]   even_q, even_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  // Multiplier pipeline: already-scaled fMul value, valid bit and product index per stage.
  logic [WIDTH-1:0]   pp_q [MUL_LAT];
  logic [WIDTH-1:0]   pp_d [MUL_LAT];
  logic               pv_q [MUL_LAT];
  logic               pv_d [MUL_LAT];
  logic [2:0]         pt_q [MUL_LAT];
  logic [2:0]         pt_d [MUL_LAT];

  logic signed [WIDTH-1:0]   op_p;
  logic signed [WIDTH-1:0]   op_q;
  logic signed [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]          fmul_val;
  logic [WIDTH-1:0]          diff;
  logic                      issue;
  logic                      unused_prod_bits;

  function automatic logic [WIDTH-1:0] comp_x(input logic [3*WIDTH-1:0] v);
    return v[3*WIDTH-1:2*WIDTH];
  endfunction
  function automatic logic [WIDTH-1:0] comp_y(input logic [3*WIDTH-1:0] v);
    return v[2*WIDTH-1:WIDTH];
  endfunction
  function automatic logic [WIDTH-1:0] comp_z(input logic [3*WIDTH-1:0] v);
    return v[WIDTH-1:0];
  endfunction

  // Full signed product; bits [FRAC +: WIDTH] equal (prod >>> FRAC) truncated to WIDTH,
  // which is the floor-toward-minus-infinity scaling with wraparound.
  assign prod             = op_p * op_q;
  assign fmul_val         = prod[FRAC +: WIDTH];
  assign unused_prod_bits = ^{prod[2*WIDTH-1:FRAC+WIDTH], prod[FRAC-1:0]};

  // Operand selection for product Pk; even/odd pairs are subtracted as they drain.
  always_comb begin
    op_p = '0;
    op_q = '0;
    case (k_q)
      3'd0:    begin op_p = comp_y(a_q); op_q = comp_z(b_q); end
      3'd1:    begin op_p = comp_z(a_q); op_q = comp_y(b_q); end
      3'd2:    begin op_p = comp_x(b_q); op_q = comp_z(a_q); end
      3'd3:    begin op_p = comp_x(a_q); op_q = comp_z(b_q); end
      3'd4:    begin op_p = comp_x(a_q); op_q = comp_y(b_q); end
      3'd5:    begin op_p = comp_x(b_q); op_q = comp_y(a_q); end
      default: begin op_p = '0;          op_q = '0;          end
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    k_d     = k_q;
    even_d  = even_q;
    issue   = 1'b0;
    diff    = even_q - pp_q[MUL_LAT-1];

    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          a_d     = io.in_a;
          b_d     = io.in_b;
          k_d     = 3'd0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        issue = 1'b1;
        k_d   = k_q + 3'd1;
        if (k_q == 3'd5) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = DRAIN;
      end
      DONE: begin
        // out_valid is always high in DONE, so out_ready alone completes the transfer.
        if (io.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    pp_d[0] = fmul_val;
    pv_d[0] = issue;
    pt_d[0] = k_q;
    for (int i = 1; i < MUL_LAT; i++) begin
      pp_d[i] = pp_q[i-1];
      pv_d[i] = pv_q[i-1];
      pt_d[i] = pt_q[i-1];
    end

    // Products may start exiting while still in ISSUE (short pipelines); P5 always
    // exits after ISSUE has ended, so its write is the one that enters DONE.
    if (pv_q[MUL_LAT-1]) begin
      if (!pt_q[MUL_LAT-1][0]) begin
        even_d = pp_q[MUL_LAT-1];
      end else begin
        case (pt_q[MUL_LAT-1])
          3'd1:    c_d[3*WIDTH-1:2*WIDTH] = diff;
          3'd3:    c_d[2*WIDTH-1:WIDTH]   = diff;
          3'd5: begin
            c_d[WIDTH-1:0] = diff;
            state_d        = DONE;
          end
          default: c_d = c_q;
        endcase
      end
    end

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      k_q         <= '0;
      even_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < MUL_LAT; i++) begin
        pp_q[i] <= '0;
        pv_q[i] <= 1'b0;
        pt_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      k_q         <= k_d;
      even_q      <= even_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      for (int i = 0; i < MUL_LAT; i++) begin
        pp_q[i] <= pp_d[i];
        pv_q[i] <= pv_d[i];
        pt_q[i] <= pt_d[i];
      end
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.out_c     = c_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_cross_product_seq.sv
module tb_cross_product_seq;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_r_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [31:0] fmul(input logic [31:0] p, input logic [31:0] q);
    longint pr;
    pr = longint'($signed(p)) * longint'($signed(q));
    pr = pr >>> 16;
    return pr[31:0];
  endfunction

  function automatic logic [95:0] cross_ref(input logic [95:0] a, input logic [95:0] b);
    logic [31:0] ax, ay, az, bx, by, bz, cx, cy, cz;
    ax = a[95:64]; ay = a[63:32]; az = a[31:0];
    bx = b[95:64]; by = b[63:32]; bz = b[31:0];
    cx = fmul(ay, bz) - fmul(az, by);
    cy = fmul(bx, az) - fmul(ax, bz);
    cz = fmul(ax, by) - fmul(bx, ay);
    return {cx, cy, cz};
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // ---------------- directed DUT, MUL_LAT=2 ----------------
  cross_product_seq_if #(.WIDTH(32)) ifd();
  logic busy_d;

  cross_product_seq #(.WIDTH(32), .FRAC(16), .MUL_LAT(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (ifd.slave),
    .busy (busy_d)
  );

  logic [95:0] d_exp_q[$];
  int          d_acc_q[$];
  logic        d_ov_prev = 1'b0;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (ifd.out_valid && !d_ov_prev) begin
        if (d_acc_q.size() == 0) fail("d_latency_unexpected");
        else chk("d_latency", 96'(cyc - d_acc_q.pop_front()), 96'd8);
      end
      if (ifd.out_valid && ifd.out_ready) begin
        if (d_exp_q.size() == 0) fail("d_out_unexpected");
        else chk("d_out_c", ifd.out_c, d_exp_q.pop_front());
      end
    end
    d_ov_prev = ifd.out_valid;
  end

  task automatic send_d(input logic [95:0] a, input logic [95:0] b, input logic [95:0] e);
    int n;
    @(negedge clk);
    ifd.in_valid = 1'b1;
    ifd.in_a     = a;
    ifd.in_b     = b;
    n = 0;
    while (!ifd.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ifd.in_ready) fail("d_accept");
    else begin
      d_exp_q.push_back(e);
      d_acc_q.push_back(cyc + 1);
    end
    @(posedge clk);
    #1 ifd.in_valid = 1'b0;
  endtask

  // Leaves the caller on the first negedge where out_valid is high.
  task automatic wait_ov(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!ifd.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ifd.out_valid) fail(name);
  endtask

  // ---------------- randomized DUTs, MUL_LAT = 1..4 ----------------
  for (genvar gi = 0; gi < 4; gi++) begin : g
    localparam int L = gi + 1;
    cross_product_seq_if #(.WIDTH(32)) ifr();
    logic        busy_r;
    logic [95:0] exp_q[$];
    int          acc_q[$];
    logic        ov_prev = 1'b0;

    cross_product_seq #(.WIDTH(32), .FRAC(16), .MUL_LAT(L)) dut_r (
      .clk  (clk),
      .rst_n(rst_r_n),
      .io   (ifr.slave),
      .busy (busy_r)
    );

    always @(negedge clk) begin
      if (rst_r_n === 1'b1) begin
        if (ifr.out_valid && !ov_prev) begin
          if (acc_q.size() == 0) fail($sformatf("r%0d_latency_unexpected", L));
          else chk($sformatf("r%0d_latency", L), 96'(cyc - acc_q.pop_front()), 96'(6 + L));
        end
        if (ifr.out_valid && ifr.out_ready) begin
          if (exp_q.size() == 0) fail($sformatf("r%0d_out_unexpected", L));
          else chk($sformatf("r%0d_out_c", L), ifr.out_c, exp_q.pop_front());
        end
      end
      ov_prev = ifr.out_valid;
    end

    initial begin
      ifr.out_ready = 1'b1;
      forever begin
        @(posedge clk);
        #1 ifr.out_ready = ($urandom_range(0, 3) != 0);
      end
    end

    initial begin
      logic [95:0] a, b;
      int n;
      ifr.in_valid = 1'b0;
      ifr.in_a     = '0;
      ifr.in_b     = '0;
      wait (rst_r_n === 1'b1);
      for (int op = 0; op < 25; op++) begin
        @(negedge clk);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        a = {$urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom};
        if (op % 5 == 4) b = a;
        ifr.in_valid = 1'b1;
        ifr.in_a     = a;
        ifr.in_b     = b;
        n = 0;
        while (!ifr.in_ready && n < 200) begin
          @(negedge clk);
          n++;
        end
        if (!ifr.in_ready) fail($sformatf("r%0d_accept", L));
        else begin
          exp_q.push_back(cross_ref(a, b));
          acc_q.push_back(cyc + 1);
        end
        @(posedge clk);
        #1 ifr.in_valid = 1'b0;
      end
      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      if (exp_q.size() != 0) fail($sformatf("r%0d_drain", L));
      done_cnt++;
    end
  end

  // ---------------- directed sequence ----------------
  localparam logic [31:0] ONE = 32'h0001_0000;

  initial begin
    logic [95:0] stall_exp;
    int n;
    rst_n         = 1'b0;
    rst_r_n       = 1'b0;
    ifd.in_valid  = 1'b0;
    ifd.in_a      = '0;
    ifd.in_b      = '0;
    ifd.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", 96'(ifd.in_ready), 96'd1);
    chk("reset_out_valid", 96'(ifd.out_valid), 96'd0);
    chk("reset_busy", 96'(busy_d), 96'd0);
    chk("reset_out_c", ifd.out_c, 96'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rst_r_n = 1'b1;

    // Basis vectors: x cross y = z.
    send_d({ONE, 32'd0, 32'd0}, {32'd0, ONE, 32'd0}, {32'd0, 32'd0, ONE});
    wait_ov("basis_wait");
    @(negedge clk);
    chk("basis_ov_drop", 96'(ifd.out_valid), 96'd0);
    chk("basis_in_ready", 96'(ifd.in_ready), 96'd1);

    // Signed mixed, integer-valued operands.
    send_d({32'h0002_0000, 32'h0003_0000, 32'h0004_0000},
           {32'h0005_0000, 32'h0006_0000, 32'h0007_0000},
           {32'hFFFD_0000, 32'h0006_0000, 32'hFFFD_0000});
    wait_ov("mixed_wait");

    // Floor toward minus infinity: -2^-16 * 0.5 scales to -1 ulp.
    send_d({32'd0, 32'hFFFF_FFFF, 32'd0}, {32'd0, 32'd0, 32'h0000_8000},
           {32'hFFFF_FFFF, 32'd0, 32'd0});
    wait_ov("floor_wait");

    // Backpressure: result held while out_ready is low, new in_valid ignored.
    @(posedge clk);
    #1 ifd.out_ready = 1'b0;
    stall_exp = {32'h0001_0000, 32'h0013_0000, 32'hFFF3_0000};
    send_d({32'h0001_0000, 32'h0002_0000, 32'h0003_0000},
           {32'h0007_0000, 32'h0001_0000, 32'h0002_0000}, stall_exp);
    wait_ov("stall_wait");
    ifd.in_valid = 1'b1;
    ifd.in_a     = {$urandom, $urandom, $urandom};
    ifd.in_b     = {$urandom, $urandom, $urandom};
    for (int i = 0; i < 20; i++) begin
      chk("stall_out_valid", 96'(ifd.out_valid), 96'd1);
      chk("stall_in_ready", 96'(ifd.in_ready), 96'd0);
      chk("stall_out_c", ifd.out_c, stall_exp);
      @(negedge clk);
    end
    ifd.in_valid = 1'b0;
    @(posedge clk);
    #1 ifd.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("stall_release_in_ready", 96'(ifd.in_ready), 96'd1);
    chk("stall_release_out_valid", 96'(ifd.out_valid), 96'd0);
    chk("stall_release_busy", 96'(busy_d), 96'd0);

    // Reset during ISSUE k=3 aborts with no output.
    send_d({32'h0005_0000, 32'h0006_0000, 32'h0007_0000}, {ONE, ONE, ONE}, 96'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midop_busy", 96'(busy_d), 96'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    d_exp_q.delete();
    d_acc_q.delete();
    @(negedge clk);
    chk("midrst_in_ready", 96'(ifd.in_ready), 96'd1);
    chk("midrst_busy", 96'(busy_d), 96'd0);
    chk("midrst_out_valid", 96'(ifd.out_valid), 96'd0);
    chk("midrst_out_c", ifd.out_c, 96'd0);
    send_d({ONE, 32'h0002_0000, 32'h0003_0000}, {ONE, 32'h0002_0000, 32'h0003_0000}, 96'd0);
    wait_ov("identical_wait");
    @(negedge clk);
    if (d_exp_q.size() != 0) fail("directed_drain");

    n = 0;
    while (done_cnt < 4 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt < 4) fail("random_done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
